iterative_shifter: RTL
======================

Name: iterative_shifter

Overview:
- Multi-cycle, parametrised shift/rotate unit for the RV32I datapath and its XLEN-generalised successors.
- Executes SLL/SRL/SRA as required by SLLI/SRLI/SRAI/SLL/SRL/SRA, plus ROL/ROR for the planned bit-manipulation extension.
- Shifts STEP bits per cycle, trading latency for area.
- Valid/ready handshakes on both sides let the core stall on it in place of the single-cycle barrel shifter in the ALU.

Parameters:
- XLEN, 32, operand/result width; power of 2, ≥ 8.
- STEP, 4, maximum bits shifted per cycle; power of 2, 1 ≤ STEP ≤ XLEN.
- SHW, $clog2(XLEN), shamt width (derived; not overridden).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  request present.
- in_ready  out  1  unit can accept a request.
- op  in  3  operation code (see package).
- operand  in  XLEN  value to shift.
- shamt  in  SHW  shift amount; only the low SHW bits exist (RV32I: shamt[4:0]).
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- result  out  XLEN  shifted value.
- illegal  out  1  qualifies result: op was not a defined code.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; all data registers cleared.
  - result=0, out_valid=0, illegal=0, busy=0, in_ready=1.
- States and transitions:
  - IDLE -> SHIFT when in_valid && in_ready && shamt != 0 && op legal.
  - IDLE -> DONE when in_valid && in_ready && (shamt == 0 || op illegal).
  - SHIFT -> DONE when the remaining count reaches 0 on this cycle's step.
  - DONE -> IDLE when out_valid && out_ready.
- in_ready = (state == IDLE). No new request is accepted in the same cycle a result is consumed; this gives 1 bubble per op.
- Accept edge: latch operand into acc, shamt into rem, op into op_q.
- SHIFT, each cycle:
  - k = min(STEP, rem); acc <= step(acc, op_q, k); rem <= rem - k.
  - Latency from accept edge to out_valid is ceil(shamt/STEP) + 1 cycles. The shamt=0 and illegal-op cases take 1 cycle.
- Step arithmetic at XLEN bits:
  - SLL: zero fill from the LSB.
  - SRL: zero fill from the MSB.
  - SRA: replicate acc[XLEN-1] on every step; sign is preserved across iterations.
  - ROL/ROR: wrap bits around; no fill.
  - k is never 0 in SHIFT.
- Illegal op (101, 110, 111): result=operand unmodified, illegal=1, no SHIFT cycles.
- DONE: result = acc and illegal are held stable while out_valid=1 && out_ready=0. Inputs are ignored.
- result is only meaningful when out_valid=1. After handoff it retains the last value.
- Reset asserted in any state aborts the op with no output. The first request after reset release is accepted normally.
- out_ready may be high before out_valid rises. The transfer then completes on the first DONE cycle.

Decomposition:
- Package shifter_pkg:
  - Op encodings OP_SLL=3'b000, OP_SRL=3'b001, OP_SRA=3'b010, OP_ROL=3'b011, OP_ROR=3'b100.
  - State encoding IDLE/SHIFT/DONE.
  - Function op_legal(op).
- Sub-module shift_step: combinational single-step shifter (acc, op, k ≤ STEP) -> next acc, parametrised on XLEN/STEP.
- The FSM, counter and handshake live in iterative_shifter.

Test Plan:
- XLEN=32, STEP=4. SRL of 52 by 4 -> result=3, out_valid 2 cycles after accept, illegal=0.
- SRA of 0x80000000 by 31 -> result=0xFFFFFFFF after 9 cycles. SRA of 0x7FFFFFF0 by 4 -> 0x07FFFFFF.
- ROR of 0x00000001 by 1 -> 0x80000000. ROL of 0x80000001 by 4 -> 0x00000018. SLL of 0x1 by 0 -> 0x1 with 1-cycle latency.
- op=3'b111, operand 0xDEADBEEF, shamt 5 -> result 0xDEADBEEF, illegal=1 after 1 cycle.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> result/out_valid stable, in_ready=0, second in_valid ignored. Raise out_ready -> handoff, in_ready=1 next cycle.
- Assert reset mid-SHIFT (SLL 0xF by 20) -> out_valid=0, busy=0, in_ready=1 immediately. A subsequent SRL 0x100 by 8 -> 0x1.

Source files
------------

// File: rtl/iterative_shifter_pkg.sv
// Shared encodings for the iterative shift/rotate unit.
package shifter_pkg;

    typedef enum logic [2:0] {
        OP_SLL = 3'b000,
        OP_SRL = 3'b001,
        OP_SRA = 3'b010,
        OP_ROL = 3'b011,
        OP_ROR = 3'b100
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_e;

    // Codes 101..111 are reserved and produce a pass-through flagged illegal.
    function automatic logic op_legal(input logic [2:0] op);
        return op <= 3'b100;
    endfunction

endpackage

// File: rtl/iterative_shifter_if.sv
// Request/response handshake bundle between the core and the shifter.
interface iterative_shifter_if #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) ();
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      op;
    logic [XLEN-1:0] operand;
    logic [SHW-1:0]  shamt;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            illegal;
    logic            busy;

    modport master (
        output in_valid, op, operand, shamt, out_ready,
        input  in_ready, out_valid, result, illegal, busy
    );

    modport slave (
        input  in_valid, op, operand, shamt, out_ready,
        output in_ready, out_valid, result, illegal, busy
    );
endinterface

// File: rtl/iterative_shifter_shift_step.sv
// One iteration of the shifter: moves acc by k (1..STEP) bits.
// Built as a STEP-way mux of fixed shifts so the logic scales with STEP,
// not with XLEN.
module shift_step
    import shifter_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int STEP = 4,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic [XLEN-1:0] i_acc,
    input  logic [2:0]      i_op,
    input  logic [SHW-1:0]  i_k,
    output logic [XLEN-1:0] o_nxt
);

    function automatic logic [XLEN-1:0] shift_by(input logic [XLEN-1:0] a,
                                                 input logic [2:0]      o,
                                                 input int              n);
        case (o)
            OP_SLL:  return a << n;
            OP_SRL:  return a >> n;
            OP_SRA:  return XLEN'($signed(a) >>> n);
            OP_ROL:  return (a << n) | (a >> (XLEN - n));
            OP_ROR:  return (a >> n) | (a << (XLEN - n));
            default: return a;
        endcase
    endfunction

    // Select the fixed-distance shift matching k; k=0 leaves acc untouched.
    always_comb begin
        o_nxt = i_acc;
        for (int j = 1; j <= STEP; j++) begin
            if (int'(i_k) == j) o_nxt = shift_by(i_acc, i_op, j);
        end
    end

endmodule

// File: rtl/iterative_shifter.sv
// Multi-cycle shift/rotate unit: shifts up to STEP bits per cycle with
// valid/ready handshakes on request and result sides.
module iterative_shifter
    import shifter_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int STEP = 4
) (
    input  logic               clk,
    input  logic               reset,
    iterative_shifter_if.slave bus
);

    localparam int SHW = $clog2(XLEN);

    state_e          r_state, w_state_nxt;
    logic [XLEN-1:0] r_acc;
    logic [SHW-1:0]  r_rem;
    logic [2:0]      r_op;
    logic            r_illegal;

    logic [XLEN-1:0] w_acc_step;
    logic [SHW-1:0]  w_k;
    logic            w_last;
    logic            w_accept;

    assign w_accept = bus.in_valid && (r_state == IDLE);
    assign w_last   = (int'(r_rem) <= STEP);

    // Step size is the smaller of STEP and what is left to shift.
    always_comb begin
        w_k = SHW'(STEP);
        if (int'(r_rem) < STEP) w_k = r_rem;
    end

    shift_step #(.XLEN(XLEN), .STEP(STEP), .SHW(SHW)) u_step (
        .i_acc (r_acc),
        .i_op  (r_op),
        .i_k   (w_k),
        .o_nxt (w_acc_step)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next state: zero shifts and illegal ops skip SHIFT entirely.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:  if (bus.in_valid)
                       w_state_nxt = (bus.shamt == '0 || !op_legal(bus.op)) ? DONE : SHIFT;
            SHIFT: if (w_last) w_state_nxt = DONE;
            DONE:  if (bus.out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Datapath: latch on accept, iterate in SHIFT, hold otherwise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_acc     <= '0;
            r_rem     <= '0;
            r_op      <= '0;
            r_illegal <= 1'b0;
        end else if (w_accept) begin
            r_acc     <= bus.operand;
            r_rem     <= bus.shamt;
            r_op      <= bus.op;
            r_illegal <= !op_legal(bus.op);
        end else if (r_state == SHIFT) begin
            r_acc <= w_acc_step;
            r_rem <= r_rem - w_k;
        end
    end

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = (r_state == DONE);
    assign bus.busy      = (r_state != IDLE);
    assign bus.result    = r_acc;
    assign bus.illegal   = r_illegal;

endmodule
